branch_pred_ctrl: RTL and testbench
===================================

Name: branch_pred_ctrl

Overview:
- Dynamic branch-prediction controller for the 5-stage pipeline.
- In ID, it looks up a 2-bit saturating-counter pattern history table (PHT) for each decoded branch and redirects fetch when the prediction is taken.
- It carries the prediction through an internal ID/EX tracking register and compares it against the EX-stage branch outcome (`taken` from the execute stage comparator).
- On a mismatch it raises the flush and the corrected PC, trains the PHT, and keeps branch and mispredict statistics.

Parameters:
- PC_W, 32, width of all PC/target buses
- PHT_BITS, 6, log2 of PHT entries (64); index = id_pc[PHT_BITS+1:2]
- CNT_W, 16, width of the saturating statistics counters

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_branch  in  1  ID instruction is beq/bne
- id_pc  in  PC_W  PC of ID instruction
- id_pc_next  in  PC_W  fall-through PC of ID instruction
- id_target  in  PC_W  branch target computed in ID
- stall  in  1  load-use stall: ID held, bubble into EX
- ex_taken  in  1  resolved outcome from execute stage comparator
- pred_taken_ID  out  1  PHT prediction for ID branch
- redirect_ID  out  1  steer fetch to redirect_pc_ID next cycle
- redirect_pc_ID  out  PC_W  equals id_target
- mispredict_EX  out  1  EX branch outcome differs from prediction; flush IF/ID
- correct_pc_EX  out  PC_W  PC fetch must load on mispredict
- branch_cnt  out  CNT_W  resolved branches, saturating
- mispred_cnt  out  CNT_W  mispredictions, saturating

Behaviour:
- Reset (reset==0 at clk edge):
  - All PHT entries go to WNT (01).
  - EX tracking register goes invalid.
  - Both counters go to 0.
  - All outputs become 0 the following cycle; redirect_pc_ID always tracks id_target.
- Lookup (combinational, 0 latency):
  - pred_taken_ID = id_valid & id_branch & PHT[idx][1].
  - redirect_ID = pred_taken_ID & !stall & !mispredict_EX.
- EX tracking register, updated each clk:
  - If mispredict_EX or stall: load invalid (bubble; the flushed or held ID instruction is not tracked).
  - Else: load {valid=id_valid&id_branch, pred=pred_taken_ID, idx, alt_pc}.
  - alt_pc = id_pc_next when pred=1, otherwise id_target.
- Resolve (combinational from the register):
  - mispredict_EX = ex_vld & (ex_taken != ex_pred).
  - correct_pc_EX = ex_alt_pc.
  - When ex_vld=0, mispredict_EX=0 and ex_taken is ignored.
- PHT update, clk edge, when ex_vld:
  - ex_taken=1: counter +1, saturates at ST (11).
  - ex_taken=0: counter −1, saturates at SNT (00).
- Same-cycle update and lookup on the same index: the lookup sees the pre-update value (no bypass).
- Priority: mispredict_EX overrides redirect_ID; the EX branch is older.
- Statistics, when ex_vld:
  - branch_cnt increments.
  - mispred_cnt increments when mispredict_EX.
  - Both hold at 2^CNT_W−1.
- Stall with a predicted-taken branch in ID: redirect_ID is withheld until the cycle stall drops. The redirect then fires exactly once, because the instruction leaves ID that cycle.
- Reset asserted mid-flight: the in-flight EX prediction is discarded with no PHT or counter update; synchronous reset has priority over all updates.

Decomposition:
- Shared package bpu_pkg:
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - PHT reset value WNT.
  - Function for saturating increment/decrement of a 2-bit counter.
- One sub-module, pht_2bit:
  - Register array with one async read port and one sync write port.
  - Synchronous active-low reset of all entries.

Test Plan:
- Reset, then a branch at id_pc=0x40 with target 0x80 and pc_next=0x44:
  - pred_taken_ID=0, redirect_ID=0.
  - Next cycle ex_taken=1 → mispredict_EX=1, correct_pc_EX=0x80.
  - PHT[16]=WT, branch_cnt=1, mispred_cnt=1.
- Same branch again after training to WT:
  - redirect_ID=1, redirect_pc_ID=0x80.
  - ex_taken=0 → mispredict_EX=1, correct_pc_EX=0x44, PHT[16]=WNT.
- Four consecutive taken resolutions on one index:
  - Counter 01→10→11→11, held at 11.
  - mispred_cnt increments only on the first.
- stall=1 with a predicted-taken branch in ID:
  - redirect_ID=0, and the next-cycle EX register is invalid (mispredict_EX=0 regardless of ex_taken).
  - stall=0 → redirect_ID=1 for exactly one cycle.
- mispredict_EX=1 while ID holds a predicted-taken branch:
  - redirect_ID=0.
  - The next cycle's EX register is invalid (flushed branch not counted).
- Same index resolved in EX and looked up in ID in the same cycle:
  - The ID prediction uses the old counter value.
  - The updated value is visible on the next lookup.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and the
// saturating update used when a branch resolves.
package bpu_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_cnt_e;

    localparam logic [1:0] PHT_RESET = WNT;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
        if (up) begin
            return (cnt == ST) ? cnt : cnt + 2'd1;
        end
        return (cnt == SNT) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_pred_ctrl_if.sv
// Pipeline-facing signals of the branch predictor; the pipeline is the master,
// the predictor the slave.
interface branch_pred_ctrl_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic             id_branch;
    logic [PC_W-1:0]  id_pc;
    logic [PC_W-1:0]  id_pc_next;
    logic [PC_W-1:0]  id_target;
    logic             stall;
    logic             ex_taken;
    logic             pred_taken_ID;
    logic             redirect_ID;
    logic [PC_W-1:0]  redirect_pc_ID;
    logic             mispredict_EX;
    logic [PC_W-1:0]  correct_pc_EX;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output id_valid, id_branch, id_pc, id_pc_next, id_target, stall, ex_taken,
        input  pred_taken_ID, redirect_ID, redirect_pc_ID, mispredict_EX, correct_pc_EX,
        input  branch_cnt, mispred_cnt
    );

    modport slave (
        input  id_valid, id_branch, id_pc, id_pc_next, id_target, stall, ex_taken,
        output pred_taken_ID, redirect_ID, redirect_pc_ID, mispredict_EX, correct_pc_EX,
        output branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/pht_2bit.sv
// Pattern history table of 2-bit saturating counters: combinational lookup,
// clocked read-modify-write training of one entry per cycle.
module pht_2bit
    import bpu_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_up
);
    localparam int unsigned ENTRIES = 1 << IDX_W;

    logic [1:0] pht_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= PHT_RESET;
            end
        end else if (wr_en) begin
            pht_q[wr_idx] <= sat_update(pht_q[wr_idx], wr_up);
        end
    end

    // No write bypass: a lookup racing a training write sees the old counter.
    assign rd_cnt = pht_q[rd_idx];

endmodule

// File: rtl/branch_pred_ctrl.sv
// Dynamic branch predictor: PHT lookup in ID, prediction tracked into EX,
// mispredict flush/correction, PHT training and branch statistics.
module branch_pred_ctrl
    import bpu_pkg::*;
#(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned PHT_BITS = 6,
    parameter int unsigned CNT_W    = 16
) (
    input logic              clk,
    input logic              reset,
    branch_pred_ctrl_if.slave bus
);
    logic [PHT_BITS-1:0] id_idx;
    logic [1:0]          id_cnt;
    logic                pred;
    logic                mispredict;

    logic                ex_vld_q, ex_vld_d;
    logic                ex_pred_q, ex_pred_d;
    logic [PHT_BITS-1:0] ex_idx_q, ex_idx_d;
    logic [PC_W-1:0]     ex_alt_pc_q, ex_alt_pc_d;
    logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;

    logic unused_pc;
    assign unused_pc = ^{bus.id_pc[PC_W-1:PHT_BITS+2], bus.id_pc[1:0]};

    assign id_idx = bus.id_pc[PHT_BITS+1:2];

    pht_2bit #(
        .IDX_W (PHT_BITS)
    ) u_pht (
        .clk    (clk),
        .reset  (reset),
        .rd_idx (id_idx),
        .rd_cnt (id_cnt),
        .wr_en  (ex_vld_q),
        .wr_idx (ex_idx_q),
        .wr_up  (bus.ex_taken)
    );

    assign pred       = bus.id_valid & bus.id_branch & id_cnt[1];
    assign mispredict = ex_vld_q & (bus.ex_taken != ex_pred_q);

    always_comb begin
        ex_vld_d    = bus.id_valid & bus.id_branch;
        ex_pred_d   = pred;
        ex_idx_d    = id_idx;
        ex_alt_pc_d = pred ? bus.id_pc_next : bus.id_target;
        // A flushed or stalled ID instruction must not be resolved in EX.
        if (mispredict || bus.stall) begin
            ex_vld_d = 1'b0;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (ex_vld_q && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispredict && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_vld_q      <= 1'b0;
            ex_pred_q     <= 1'b0;
            ex_idx_q      <= '0;
            ex_alt_pc_q   <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ex_vld_q      <= ex_vld_d;
            ex_pred_q     <= ex_pred_d;
            ex_idx_q      <= ex_idx_d;
            ex_alt_pc_q   <= ex_alt_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // The older EX branch wins: a mispredict suppresses any ID redirect.
    assign bus.pred_taken_ID  = pred;
    assign bus.redirect_ID    = pred & ~bus.stall & ~mispredict;
    assign bus.redirect_pc_ID = bus.id_target;
    assign bus.mispredict_EX  = mispredict;
    assign bus.correct_pc_EX  = ex_alt_pc_q;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl: training, stall/flush interaction and
// same-cycle lookup/update ordering, with hand-computed expectations.
module tb_branch_pred_ctrl;
    import bpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_pred_ctrl_if #(.PC_W(32), .CNT_W(16)) bus ();

    branch_pred_ctrl #(
        .PC_W     (32),
        .PHT_BITS (6),
        .CNT_W    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic st, input logic tk);
        bus.id_valid   = v;
        bus.id_branch  = v;
        bus.id_pc      = pc;
        bus.id_target  = tgt;
        bus.id_pc_next = pc + 32'd4;
        bus.stall      = st;
        bus.ex_taken   = tk;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.id_valid = 1'b0; bus.id_branch = 1'b0; bus.id_pc = '0; bus.id_pc_next = '0;
        bus.id_target = '0; bus.stall = 1'b0; bus.ex_taken = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rst_pred", {31'd0, bus.pred_taken_ID}, 32'd0);
        chk("rst_redirect", {31'd0, bus.redirect_ID}, 32'd0);
        chk("rst_mispred", {31'd0, bus.mispredict_EX}, 32'd0);
        chk("rst_correct_pc", bus.correct_pc_EX, 32'd0);
        chk("rst_branch_cnt", {16'd0, bus.branch_cnt}, 32'd0);
        chk("rst_mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd0);
        chk("rst_pht16", {30'd0, dut.u_pht.pht_q[16]}, 32'd1);

        // First encounter of branch at 0x40: predicted not taken, resolves taken.
        drive(1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
        chk("b1_pred", {31'd0, bus.pred_taken_ID}, 32'd0);
        chk("b1_redirect", {31'd0, bus.redirect_ID}, 32'd0);
        chk("b1_redirect_pc", bus.redirect_pc_ID, 32'h80);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("b1_mispred", {31'd0, bus.mispredict_EX}, 32'd1);
        chk("b1_correct_pc", bus.correct_pc_EX, 32'h80);
        step();
        chk("b1_pht16", {30'd0, dut.u_pht.pht_q[16]}, 32'd2);
        chk("b1_branch_cnt", {16'd0, bus.branch_cnt}, 32'd1);
        chk("b1_mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd1);

        // Trained to WT: predicted taken, resolves not taken.
        drive(1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
        chk("b2_pred", {31'd0, bus.pred_taken_ID}, 32'd1);
        chk("b2_redirect", {31'd0, bus.redirect_ID}, 32'd1);
        chk("b2_redirect_pc", bus.redirect_pc_ID, 32'h80);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("b2_mispred", {31'd0, bus.mispredict_EX}, 32'd1);
        chk("b2_correct_pc", bus.correct_pc_EX, 32'h44);
        step();
        chk("b2_pht16", {30'd0, dut.u_pht.pht_q[16]}, 32'd1);
        chk("b2_branch_cnt", {16'd0, bus.branch_cnt}, 32'd2);
        chk("b2_mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd2);

        // Four taken resolutions: 01 -> 10 -> 11 -> 11 -> 11.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
            step();
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            chk($sformatf("sat%0d_mispred", i), {31'd0, bus.mispredict_EX},
                (i == 0) ? 32'd1 : 32'd0);
            step();
            chk($sformatf("sat%0d_pht16", i), {30'd0, dut.u_pht.pht_q[16]},
                (i == 0) ? 32'd2 : 32'd3);
        end
        chk("sat_branch_cnt", {16'd0, bus.branch_cnt}, 32'd6);
        chk("sat_mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd3);

        // Stall holds a predicted-taken branch in ID.
        drive(1'b1, 32'h40, 32'h80, 1'b1, 1'b0);
        chk("stall_pred", {31'd0, bus.pred_taken_ID}, 32'd1);
        chk("stall_redirect", {31'd0, bus.redirect_ID}, 32'd0);
        step();
        drive(1'b1, 32'h40, 32'h80, 1'b0, 1'b1);
        chk("stall_ex_bubble", {31'd0, bus.mispredict_EX}, 32'd0);
        chk("unstall_redirect", {31'd0, bus.redirect_ID}, 32'd1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("unstall_once", {31'd0, bus.redirect_ID}, 32'd0);
        chk("unstall_mispred", {31'd0, bus.mispredict_EX}, 32'd0);
        step();
        chk("unstall_branch_cnt", {16'd0, bus.branch_cnt}, 32'd7);
        chk("unstall_mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd3);

        // Mispredict in EX while ID holds a predicted-taken branch.
        drive(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
        chk("fl_pred_b0", {31'd0, bus.pred_taken_ID}, 32'd0);
        step();
        drive(1'b1, 32'h40, 32'h80, 1'b0, 1'b1);
        chk("fl_mispred", {31'd0, bus.mispredict_EX}, 32'd1);
        chk("fl_correct_pc", bus.correct_pc_EX, 32'h200);
        chk("fl_id_pred", {31'd0, bus.pred_taken_ID}, 32'd1);
        chk("fl_redirect", {31'd0, bus.redirect_ID}, 32'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("fl_ex_invalid", {31'd0, bus.mispredict_EX}, 32'd0);
        step();
        chk("fl_branch_cnt", {16'd0, bus.branch_cnt}, 32'd8);
        chk("fl_mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd4);
        chk("fl_pht0", {30'd0, dut.u_pht.pht_q[0]}, 32'd2);

        // Same index resolved in EX and looked up in ID in one cycle.
        drive(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
        chk("sc_pred_issue", {31'd0, bus.pred_taken_ID}, 32'd1);
        step();
        drive(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
        chk("sc_mispred", {31'd0, bus.mispredict_EX}, 32'd1);
        chk("sc_pred_old", {31'd0, bus.pred_taken_ID}, 32'd1);
        step();
        drive(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
        chk("sc_pred_new", {31'd0, bus.pred_taken_ID}, 32'd0);
        chk("sc_branch_cnt", {16'd0, bus.branch_cnt}, 32'd9);
        chk("sc_mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd5);

        // Reset with a branch in flight discards it.
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        reset = 1'b1;
        #1;
        chk("mr_mispred", {31'd0, bus.mispredict_EX}, 32'd0);
        chk("mr_branch_cnt", {16'd0, bus.branch_cnt}, 32'd0);
        chk("mr_mispred_cnt", {16'd0, bus.mispred_cnt}, 32'd0);
        chk("mr_pht0", {30'd0, dut.u_pht.pht_q[0]}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
